// File: rtl/bist_6_3_pkg.sv
// Shared types, constants and helpers for the 6:3 counter BIST wrapper.
// Build option: define BIST_LFSR_EN to replace the binary up-counter pattern
// source (64 patterns, 0..63) with a 6-bit Fibonacci LFSR x^6+x^5+1 seeded
// with 6'b000001 (63 nonzero patterns).
package bist_6_3_pkg;

  localparam int unsigned PAT_W = 6;
  localparam int unsigned OUT_W = 3;
  localparam int unsigned ERR_W = 7;
  localparam int unsigned SIG_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } bist_state_e;

  // Low-order terms of x^8+x^4+x^3+x^2+1; the x^8 term is the shifted-out bit.
  localparam logic [SIG_W-1:0] MISR_POLY = 8'h1D;

  // Feedback taps of x^6+x^5+1 (bits 5 and 4 of the shift register).
  localparam logic [PAT_W-1:0] LFSR_TAPS = 6'b110000;

  localparam logic [ERR_W-1:0] ERR_MAX = 7'd64;

`ifdef BIST_LFSR_EN
  localparam int unsigned      PAT_CNT   = 63;
  localparam logic [PAT_W-1:0] PAT_FIRST = 6'b000001;
`else
  localparam int unsigned      PAT_CNT   = 64;
  localparam logic [PAT_W-1:0] PAT_FIRST = 6'b000000;
`endif

  localparam logic [PAT_W-1:0] PAT_LAST_IDX = PAT_W'(PAT_CNT - 1);

  // Golden 6:3 counter result.
  function automatic logic [OUT_W-1:0] popcount6(input logic [PAT_W-1:0] p);
    logic [OUT_W-1:0] c;
    c = '0;
    for (int i = 0; i < int'(PAT_W); i++) c = c + OUT_W'(p[i]);
    return c;
  endfunction

  // Successor of the current pattern in the selected source.
  function automatic logic [PAT_W-1:0] pat_next(input logic [PAT_W-1:0] p);
`ifdef BIST_LFSR_EN
    return {p[PAT_W-2:0], ^(p & LFSR_TAPS)};
`else
    return p + PAT_W'(1);
`endif
  endfunction

endpackage

// File: rtl/bist_misr8.sv
// 8-bit MISR compacting the 3-bit counter result.
// Ports: clk, rst (async high) ; load/seed reload the register (priority over
// en) ; en shifts once with din folded into bits [2:0] ; sig is the contents.
module bist_misr8
  import bist_6_3_pkg::*;
#(
  parameter logic [SIG_W-1:0] RST_VAL = 8'hFF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [SIG_W-1:0] seed,
  input  logic             en,
  input  logic [OUT_W-1:0] din,
  output logic [SIG_W-1:0] sig
);

  // Galois-style shift: multiply by x modulo the polynomial, then add din.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig <= RST_VAL;
    end else if (load) begin
      sig <= seed;
    end else if (en) begin
      sig <= {sig[SIG_W-2:0], 1'b0}
           ^ (sig[SIG_W-1] ? MISR_POLY : SIG_W'(0))
           ^ {{(SIG_W-OUT_W){1'b0}}, din};
    end
  end

endmodule

// File: rtl/bist_tpg_ora_6_3.sv
// BIST wrapper for the combinational 6:3 counter: pattern generator (TPG)
// feeding the counter's x, and response analyser (ORA) checking its o.
// Ports: clk, rst (async high), start (run request, honoured in IDLE/DONE);
// tpg_x/tpg_valid (stimulus), cut_o (counter result); busy, done, pass,
// err_cnt, first_fail, signature (run status and results).
// Build option: BIST_LFSR_EN selects the LFSR pattern source (see package).
module bist_tpg_ora_6_3
  import bist_6_3_pkg::*;
#(
  parameter int unsigned      CUT_LAT   = 0,
  parameter logic [SIG_W-1:0] MISR_SEED = 8'hFF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [PAT_W-1:0] tpg_x,
  output logic             tpg_valid,
  input  logic [OUT_W-1:0] cut_o,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic [PAT_W-1:0] first_fail,
  output logic [SIG_W-1:0] signature
);

  localparam int unsigned DRN_W      = 2;
  localparam int unsigned DRAIN_LAST = (CUT_LAT == 0) ? 0 : CUT_LAT - 1;

  bist_state_e state, state_nxt;

  logic [PAT_W-1:0] pat_idx;
  logic [DRN_W-1:0] drain_cnt;
  logic             run_start;
  logic             last_issued;
  logic             drain_done;
  logic             dly_valid;
  logic [PAT_W-1:0] dly_pat;
  logic [OUT_W-1:0] exp_o;
  logic             mism;
  logic [ERR_W-1:0] err_nxt;

  assign run_start   = start && (state == ST_IDLE || state == ST_DONE);
  assign last_issued = (pat_idx == PAT_LAST_IDX);
  assign drain_done  = (drain_cnt == DRN_W'(DRAIN_LAST));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; CUT_LAT=0 has nothing in flight so DRAIN is skipped.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (start) state_nxt = ST_RUN;
      ST_RUN:   if (last_issued) state_nxt = (CUT_LAT == 0) ? ST_DONE : ST_DRAIN;
      ST_DRAIN: if (drain_done) state_nxt = ST_DONE;
      ST_DONE:  if (start) state_nxt = ST_RUN;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Pattern source: tpg_x holds its last value once the run stops issuing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tpg_x     <= '0;
      tpg_valid <= 1'b0;
      pat_idx   <= '0;
    end else if (run_start) begin
      tpg_x     <= PAT_FIRST;
      tpg_valid <= 1'b1;
      pat_idx   <= '0;
    end else if (state == ST_RUN) begin
      if (last_issued) begin
        tpg_valid <= 1'b0;
      end else begin
        tpg_x   <= pat_next(tpg_x);
        pat_idx <= pat_idx + PAT_W'(1);
      end
    end
  end

  // Drain cycle counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    drain_cnt <= '0;
    else if (state == ST_DRAIN) drain_cnt <= drain_cnt + DRN_W'(1);
    else                        drain_cnt <= '0;
  end

  // Expected-value delay line aligning {valid, pattern} with cut_o.
  generate
    if (CUT_LAT == 0) begin : g_no_dly
      assign dly_valid = tpg_valid;
      assign dly_pat   = tpg_x;
    end else begin : g_dly
      logic [PAT_W:0] dly_q [CUT_LAT];
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < int'(CUT_LAT); i++) dly_q[i] <= '0;
        end else if (run_start) begin
          for (int i = 0; i < int'(CUT_LAT); i++) dly_q[i] <= '0;
        end else begin
          dly_q[0] <= {tpg_valid, tpg_x};
          for (int i = 1; i < int'(CUT_LAT); i++) dly_q[i] <= dly_q[i-1];
        end
      end
      assign dly_valid = dly_q[CUT_LAT-1][PAT_W];
      assign dly_pat   = dly_q[CUT_LAT-1][PAT_W-1:0];
    end
  endgenerate

  assign exp_o   = popcount6(dly_pat);
  assign mism    = dly_valid && (cut_o != exp_o);
  assign err_nxt = (mism && err_cnt != ERR_MAX) ? err_cnt + ERR_W'(1) : err_cnt;

  // Result registers; pass includes the compare made on the DONE-entry edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt    <= '0;
      first_fail <= '0;
      pass       <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      busy <= (state_nxt == ST_RUN) || (state_nxt == ST_DRAIN);
      done <= (state_nxt == ST_DONE);
      if (run_start) begin
        err_cnt    <= '0;
        first_fail <= '0;
        pass       <= 1'b0;
      end else begin
        err_cnt <= err_nxt;
        if (mism && err_cnt == '0) first_fail <= dly_pat;
        if (state != ST_DONE && state_nxt == ST_DONE) pass <= (err_nxt == '0);
      end
    end
  end

  bist_misr8 #(
    .RST_VAL (MISR_SEED)
  ) u_misr (
    .clk  (clk),
    .rst  (rst),
    .load (run_start),
    .seed (MISR_SEED),
    .en   (dly_valid),
    .din  (cut_o),
    .sig  (signature)
  );

endmodule

// File: tb/tb_bist_tpg_ora_6_3.sv
// Self-checking bench: two wrappers (CUT_LAT 0 and 2) each driving a table-based
// counter model; run results are compared against a pattern-list reference.
module tb_bist_tpg_ora_6_3;

`ifdef BIST_LFSR_EN
  localparam int N_PAT = 63;
`else
  localparam int N_PAT = 64;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       start      [2];
  logic [5:0] tpg_x      [2];
  logic       tpg_valid  [2];
  logic [2:0] cut_o      [2];
  logic       busy       [2];
  logic       done       [2];
  logic       pass       [2];
  logic [6:0] err_cnt    [2];
  logic [5:0] first_fail [2];
  logic [7:0] signature  [2];

  logic [2:0] cut_tbl [2][64];
  logic [2:0] junk;
  logic [5:0] p1, p2;
  logic       v1, v2;
  logic [5:0] pat_seq [64];
  logic [5:0] obs_first [6];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  always @(negedge clk) junk <= 3'($urandom);

  // Two-stage pipe in front of the latency-2 counter model.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      p1 <= '0; p2 <= '0; v1 <= 1'b0; v2 <= 1'b0;
    end else begin
      p1 <= tpg_x[1]; p2 <= p1; v1 <= tpg_valid[1]; v2 <= v1;
    end
  end

  // Outside live cycles the counter output is garbage and must be ignored.
  assign cut_o[0] = tpg_valid[0] ? cut_tbl[0][tpg_x[0]] : junk;
  assign cut_o[1] = v2 ? cut_tbl[1][p2] : junk;

  bist_tpg_ora_6_3 #(.CUT_LAT(0), .MISR_SEED(8'hFF)) u_dut0 (
    .clk(clk), .rst(rst), .start(start[0]), .tpg_x(tpg_x[0]), .tpg_valid(tpg_valid[0]),
    .cut_o(cut_o[0]), .busy(busy[0]), .done(done[0]), .pass(pass[0]),
    .err_cnt(err_cnt[0]), .first_fail(first_fail[0]), .signature(signature[0])
  );

  bist_tpg_ora_6_3 #(.CUT_LAT(2), .MISR_SEED(8'hFF)) u_dut2 (
    .clk(clk), .rst(rst), .start(start[1]), .tpg_x(tpg_x[1]), .tpg_valid(tpg_valid[1]),
    .cut_o(cut_o[1]), .busy(busy[1]), .done(done[1]), .pass(pass[1]),
    .err_cnt(err_cnt[1]), .first_fail(first_fail[1]), .signature(signature[1])
  );

  // Pattern order derived from the source definition.
  task automatic gen_patterns();
    int v;
`ifdef BIST_LFSR_EN
    v = 1;
    for (int i = 0; i < N_PAT; i++) begin
      pat_seq[i] = 6'(v);
      v = ((v * 2) % 64) + (((v >> 5) ^ (v >> 4)) & 1);
    end
`else
    v = 0;
    for (int i = 0; i < N_PAT; i++) pat_seq[i] = 6'(i);
`endif
    pat_seq[63] = (N_PAT == 64) ? pat_seq[63] : 6'd0;
  endtask

  // mode: 0 good, 1 o[0] sa0, 2 o[2] sa0, 3 random sparse faults, 4 always wrong
  task automatic set_tbl(input int k, input int mode);
    logic [5:0] pv;
    logic [2:0] pc;
    for (int p = 0; p < 64; p++) begin
      pv = 6'(p);
      pc = 3'($countones(pv));
      case (mode)
        1:       cut_tbl[k][p] = pc & 3'b110;
        2:       cut_tbl[k][p] = pc & 3'b011;
        3:       cut_tbl[k][p] = ($urandom_range(0, 7) == 0) ? pc ^ 3'($urandom_range(1, 7)) : pc;
        4:       cut_tbl[k][p] = ~pc;
        default: cut_tbl[k][p] = pc;
      endcase
    end
  endtask

  // Reference: walk the pattern list, compare with popcount, compact with MISR.
  task automatic model(input int k, output int e_err, output logic [5:0] e_ff,
                       output logic [7:0] e_sig);
    int s;
    logic [5:0] p;
    logic [2:0] o;
    s = 'hFF; e_err = 0; e_ff = '0;
    for (int i = 0; i < N_PAT; i++) begin
      p = pat_seq[i];
      o = cut_tbl[k][p];
      if (int'(o) != $countones(p)) begin
        if (e_err == 0) e_ff = p;
        e_err = (e_err < 64) ? e_err + 1 : 64;
      end
      s = s * 2;
      if (s >= 256) s = s ^ 'h11D;
      s = s ^ int'(o);
    end
    e_sig = 8'(s);
  endtask

  task automatic run_check(input int k, input int lat, input int extra_start, input string tag);
    int e_err, done_at, seq_bad, busy_bad, distinct;
    logic [5:0] e_ff, ff_hold;
    logic [7:0] e_sig, sig_hold;
    logic [6:0] err_hold;
    logic seen [64];
    model(k, e_err, e_ff, e_sig);
    for (int i = 0; i < 64; i++) seen[i] = 1'b0;
    done_at = -1; seq_bad = 0; busy_bad = 0; distinct = 0;
    @(negedge clk); start[k] = 1'b1;
    for (int n = 0; n < N_PAT + lat + 20; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (n == 0) begin
        total++;
        if (err_cnt[k] !== 7'd0 || first_fail[k] !== 6'd0 || done[k] !== 1'b0) begin
          bad++;
          $display("FAIL %s start_clear got err=%0d ff=%0d done=%0b exp 0/0/0", tag, err_cnt[k], first_fail[k], done[k]);
        end
      end
      if (n < N_PAT) begin
        if (tpg_valid[k] !== 1'b1 || tpg_x[k] !== pat_seq[n]) seq_bad++;
        if (!seen[tpg_x[k]]) begin seen[tpg_x[k]] = 1'b1; distinct++; end
        if (n < 6) obs_first[n] = tpg_x[k];
      end else if (tpg_valid[k] !== 1'b0 || tpg_x[k] !== pat_seq[N_PAT-1]) begin
        seq_bad++;
      end
      if (done[k] === 1'b1) begin
        done_at = n;
        start[k] = 1'b0;
        break;
      end
      if (busy[k] !== 1'b1) busy_bad++;
      start[k] = (n == extra_start) ? 1'b1 : 1'b0;
    end
    start[k] = 1'b0;
    total++; if (done_at != N_PAT + lat) begin bad++; $display("FAIL %s done_edge got=%0d exp=%0d", tag, done_at, N_PAT + lat); end
    total++; if (seq_bad != 0) begin bad++; $display("FAIL %s tpg_seq got %0d bad cycles exp 0", tag, seq_bad); end
    total++; if (busy_bad != 0) begin bad++; $display("FAIL %s busy got %0d low cycles exp 0", tag, busy_bad); end
    total++; if (distinct != N_PAT) begin bad++; $display("FAIL %s distinct got=%0d exp=%0d", tag, distinct, N_PAT); end
    total++; if (busy[k] !== 1'b0) begin bad++; $display("FAIL %s busy_in_done got=%0b exp=0", tag, busy[k]); end
    total++; if (pass[k] !== (e_err == 0)) begin bad++; $display("FAIL %s pass got=%0b exp=%0b", tag, pass[k], e_err == 0); end
    total++; if (err_cnt[k] !== 7'(e_err)) begin bad++; $display("FAIL %s err_cnt got=%0d exp=%0d", tag, err_cnt[k], e_err); end
    total++; if (first_fail[k] !== e_ff) begin bad++; $display("FAIL %s first_fail got=%0h exp=%0h", tag, first_fail[k], e_ff); end
    total++; if (signature[k] !== e_sig) begin bad++; $display("FAIL %s signature got=%0h exp=%0h", tag, signature[k], e_sig); end
    err_hold = err_cnt[k]; ff_hold = first_fail[k]; sig_hold = signature[k];
    repeat (3) @(negedge clk);
    total++;
    if (done[k] !== 1'b1 || err_cnt[k] !== err_hold || first_fail[k] !== ff_hold || signature[k] !== sig_hold) begin
      bad++;
      $display("FAIL %s hold got done=%0b err=%0d sig=%0h exp done=1 err=%0d sig=%0h", tag, done[k], err_cnt[k], signature[k], err_hold, sig_hold);
    end
  endtask

  task automatic check_reset_vals(input int k, input string tag);
    total++;
    if (tpg_x[k] !== 6'd0 || tpg_valid[k] !== 1'b0 || busy[k] !== 1'b0 || done[k] !== 1'b0 || pass[k] !== 1'b0) begin
      bad++;
      $display("FAIL %s ctl got x=%0h v=%0b busy=%0b done=%0b pass=%0b exp all 0", tag, tpg_x[k], tpg_valid[k], busy[k], done[k], pass[k]);
    end
    total++;
    if (err_cnt[k] !== 7'd0 || first_fail[k] !== 6'd0 || signature[k] !== 8'hFF) begin
      bad++;
      $display("FAIL %s results got err=%0d ff=%0h sig=%0h exp 0/0/ff", tag, err_cnt[k], first_fail[k], signature[k]);
    end
  endtask

  task automatic test_reset();
    check_reset_vals(0, "reset_dut0");
    check_reset_vals(1, "reset_dut2");
  endtask

  task automatic test_good();
    set_tbl(0, 0);
    run_check(0, 0, -1, "good_lat0");
  endtask

  task automatic test_first_patterns();
    logic [5:0] ref6 [6];
`ifdef BIST_LFSR_EN
    ref6 = '{6'h01, 6'h02, 6'h04, 6'h08, 6'h10, 6'h21};
`else
    ref6 = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05};
`endif
    for (int i = 0; i < 6; i++) begin
      total++;
      if (obs_first[i] !== ref6[i]) begin
        bad++;
        $display("FAIL first_patterns[%0d] got=%0h exp=%0h", i, obs_first[i], ref6[i]);
      end
    end
  endtask

  task automatic test_stuck_o0();
    set_tbl(0, 1);
    run_check(0, 0, -1, "o0_sa0");
  endtask

  task automatic test_restart_in_done();
    set_tbl(0, 3);
    run_check(0, 0, -1, "restart_in_done");
  endtask

  task automatic test_stuck_o2_lat2();
    set_tbl(1, 2);
    run_check(1, 2, -1, "o2_sa0_lat2");
  endtask

  task automatic test_random_faults();
    for (int r = 0; r < 3; r++) begin
      set_tbl(r % 2, 3);
      run_check(r % 2, (r % 2) * 2, -1, "random_faults");
    end
  endtask

  task automatic test_saturate();
    set_tbl(0, 4);
    run_check(0, 0, -1, "all_wrong");
  endtask

  task automatic test_start_in_run();
    set_tbl(0, 3);
    run_check(0, 0, 10, "start_in_run_lat0");
    set_tbl(1, 3);
    run_check(1, 2, 64, "start_in_drain_lat2");
  endtask

  task automatic test_reset_mid();
    int waited;
    set_tbl(0, 1);
    @(negedge clk); start[0] = 1'b1;
    @(negedge clk); start[0] = 1'b0;
    waited = 0;
    while (tpg_x[0] !== 6'd20 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    total++;
    if (waited >= 100) begin bad++; $display("FAIL reset_mid wait got timeout exp pattern 20"); end
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check_reset_vals(0, "reset_mid_async");
    @(negedge clk); rst = 1'b0;
    check_reset_vals(0, "reset_mid_released");
    set_tbl(0, 0);
    run_check(0, 0, -1, "after_reset");
  endtask

  initial begin
    rst = 1'b1;
    start[0] = 1'b0;
    start[1] = 1'b0;
    gen_patterns();
    set_tbl(0, 0);
    set_tbl(1, 0);
    repeat (3) @(negedge clk);
    test_reset();
    rst = 1'b0;
    test_good();
    test_first_patterns();
    test_stuck_o0();
    test_restart_in_done();
    test_stuck_o2_lat2();
    test_random_faults();
    test_saturate();
    test_start_in_run();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
